// File: rtl/key_event_gen.sv
// Keypad front end: 2-FF synchroniser, per-key debounce, press/release pulses,
// auto-repeat on direction keys and a priority-encoded key code.
module key_event_gen #(
  parameter int                N_KEYS       = 16,
  parameter int                DB_CYCLES    = 500000,
  parameter int                REPEAT_DELAY = 50000000,
  parameter int                REPEAT_RATE  = 10000000,
  parameter logic [N_KEYS-1:0] REPEAT_MASK  = N_KEYS'(16'h00E4)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] btn_raw,
  output logic [N_KEYS-1:0] held,
  output logic [N_KEYS-1:0] press,
  // 'release' is a reserved word, hence the suffix
  output logic [N_KEYS-1:0] release_pulse,
  output logic              key_valid,
  output logic [3:0]        key_code
);

  localparam int DBW     = $clog2(DB_CYCLES);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(RPT_MAX);

  localparam logic [DBW-1:0] DB_TERM = DBW'(DB_CYCLES - 1);
  localparam logic [RW-1:0]  RD_TERM = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0]  RR_TERM = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_e;

  logic [N_KEYS-1:0] meta_q, sync_q;
  logic [N_KEYS-1:0] held_q, held_d, held_dly_q;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic [N_KEYS-1:0] rep_q, rep_d;
  logic              key_valid_q, key_valid_d;
  logic [3:0]        key_code_q, key_code_d;
  logic [DBW-1:0]    db_cnt_q [N_KEYS];
  logic [DBW-1:0]    db_cnt_d [N_KEYS];

  // Debounce: count consecutive cycles the synced level disagrees with held.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    held_d = held_q;
    for (int i = 0; i < N_KEYS; i++) begin
      db_cnt_d[i] = '0;
      if (sync_q[i] != held_q[i]) begin
        if (db_cnt_q[i] == DB_TERM) begin
          held_d[i] = sync_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Repeat strobes are gated by held so a key released this cycle never repeats.
  always_comb begin
    press_d     = (held_q & ~held_dly_q) | (rep_q & held_q);
    release_d   = ~held_q & held_dly_q;
    key_valid_d = |press_d;
    key_code_d  = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (press_d[i]) key_code_d = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      meta_q      <= '0;
      sync_q      <= '0;
      held_q      <= '0;
      held_dly_q  <= '0;
      press_q     <= '0;
      release_q   <= '0;
      rep_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      // NOTE: the counter array is tiny and must restart from zero, so it is reset explicitly.
      for (int i = 0; i < N_KEYS; i++) db_cnt_q[i] <= '0;
    end else begin
      meta_q      <= btn_raw;
      sync_q      <= meta_q;
      held_q      <= held_d;
      held_dly_q  <= held_q;
      press_q     <= press_d;
      release_q   <= release_d;
      rep_q       <= rep_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      for (int i = 0; i < N_KEYS; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_rpt
    if (REPEAT_MASK[g]) begin : g_on
      rpt_state_e     state_q, state_d;
      logic [RW-1:0]  cnt_q, cnt_d;
      logic           fire_d;

      always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        fire_d  = 1'b0;
        case (state_q)
          RPT_IDLE: begin
            if (held_q[g]) state_d = RPT_DELAY;
          end
          RPT_DELAY: begin
            if (!held_q[g]) begin
              state_d = RPT_IDLE;
            end else if (cnt_q == RD_TERM) begin
              state_d = RPT_REPEAT;
              fire_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          RPT_REPEAT: begin
            if (!held_q[g]) begin
              state_d = RPT_IDLE;
            end else if (cnt_q == RR_TERM) begin
              fire_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: state_d = RPT_IDLE;
        endcase
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= RPT_IDLE;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      assign rep_d[g] = fire_d;
    end else begin : g_off
      assign rep_d[g] = 1'b0;
    end
  end

  assign held          = held_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign key_valid     = key_valid_q;
  assign key_code      = key_code_q;

endmodule
